// File: rtl/register_file_sb.sv
// Parametrised integer register file with two write ports and a per-register
// write-in-flight scoreboard. Optional macro REGFILE_BYPASS_EN adds write-to-read forwarding.
module register_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_ready,
    output logic [ADDR_W:0]          busy_count
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [ADDR_W:0]     busy_cnt_nxt;
    logic                wr0_hit;
    logic                wr1_hit;
    logic                grant_set;

    assign wr0_hit = wr0_en && (wr0_addr != '0);
    assign wr1_hit = wr1_en && (wr1_addr != '0);

    // Issue handshake: a reservation is granted at the posedge where issue_valid
    // and issue_ready are both high; issue_ready never depends on issue_valid.
    assign issue_ready = (issue_addr == '0) || !busy[issue_addr];
    assign grant_set   = issue_valid && issue_ready && (issue_addr != '0);

    // Clears are applied before the set so a same-edge grant keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wr0_hit) busy_nxt[wr0_addr] = 1'b0;
        if (wr1_hit) busy_nxt[wr1_addr] = 1'b0;
        if (grant_set) busy_nxt[issue_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
        busy_cnt_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_cnt_nxt = busy_cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr0_hit) regs[wr0_addr] <= wr0_data;
            // Port 1 is the later assignment, so it wins a same-address collision.
            if (wr1_hit) regs[wr1_addr] <= wr1_data;
            busy       <= busy_nxt;
            busy_count <= busy_cnt_nxt;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;

        assign a = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            d = (a == '0) ? '0 : regs[a];
            b = (a != '0) && busy[a];
`ifdef REGFILE_BYPASS_EN
            if (wr1_hit && (wr1_addr == a)) begin
                d = wr1_data;
                b = grant_set && (issue_addr == a);
            end else if (wr0_hit && (wr0_addr == a)) begin
                d = wr0_data;
                b = grant_set && (issue_addr == a);
            end
`endif
        end

        assign rd_data[p*DATA_W +: DATA_W] = d;
        assign rd_busy[p]                  = b;
    end

endmodule
